// File: rtl/ecc_enc_pkg.sv
// Shared types and constants for the multi-mode extended-Hamming encoder.
// No logic of its own; constants and a constant-foldable helper only.
// No flow control here; used by the pipeline and its parity generator.
package ecc_enc_pkg;

  typedef enum logic [1:0] {
    MODE_8_4     = 2'd0,
    MODE_16_11   = 2'd1,
    MODE_32_26   = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

  // Widest info word, widest p (Hamming bits + overall bit), widest r.
  localparam int INFO_MAX_W = 26;
  localparam int PAR_MAX_W  = 6;
  localparam int HAM_MAX_W  = 5;

  // Indexed by mode: k info bits and p = r + 1 parity bits (0 for illegal).
  localparam int INFO_W   [4] = '{4, 11, 26, 0};
  localparam int PARITY_W [4] = '{4, 5, 6, 0};

  // Column code of info bit i: the i-th integer in [1, 2^r - 1] that is not
  // a power of two. Returns 0 if i is beyond the code's info length.
  function automatic logic [HAM_MAX_W-1:0] col_code(input int i, input int r);
    logic [HAM_MAX_W-1:0] code;
    int                   n;
    code = '0;
    n    = 0;
    for (int v = 1; v < (1 << HAM_MAX_W); v++) begin
      if ((v < (1 << r)) && ((v & (v - 1)) != 0)) begin
        if (n == i) code = HAM_MAX_W'(v);
        n++;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/ecc_enc_pipe_if.sv
// Info-word in / codeword out handshake bundle of the encoder pipeline.
// No latency; wires only.
// valid/ready on both sides; master drives words in and ready out.
interface ecc_enc_pipe_if #(
  parameter int INFO_WIDTH = 26,
  parameter int CW_WIDTH   = 32
);
  logic [INFO_WIDTH-1:0] data_in;
  logic [1:0]            mod;
  logic                  in_valid;
  logic                  in_ready;
  logic [CW_WIDTH-1:0]   data_out;
  logic                  out_err;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output data_in, mod, in_valid, out_ready,
    input  in_ready, data_out, out_err, out_valid
  );

  modport slave (
    input  data_in, mod, in_valid, out_ready,
    output in_ready, data_out, out_err, out_valid
  );
endinterface

// File: rtl/ecc_parity_gen.sv
// Hamming parity bits (r = p-1) of an already-masked info word.
// Purely combinational, zero latency.
// No flow control; bits at or above the mode's r are forced to zero.
module ecc_parity_gen
  import ecc_enc_pkg::*;
#(
  parameter int INFO_WIDTH = INFO_MAX_W
) (
  input  logic [INFO_WIDTH-1:0] info,
  input  mode_e                 mode,
  output logic [HAM_MAX_W-1:0]  ham
);

  // Info bits above k are already zero, so the widest code table serves all modes.
  always_comb begin
    logic [HAM_MAX_W-1:0] code;
    ham  = '0;
    code = '0;
    for (int i = 0; i < INFO_WIDTH; i++) begin
      code = col_code(i, HAM_MAX_W);
      for (int j = 0; j < HAM_MAX_W; j++) begin
        if (code[j]) ham[j] = ham[j] ^ info[i];
      end
    end
    for (int j = 0; j < HAM_MAX_W; j++) begin
      if (j >= PARITY_W[mode] - 1) ham[j] = 1'b0;
    end
  end

endmodule

// File: rtl/ecc_enc_pipe.sv
// Two-stage multi-mode extended-Hamming encoder with saturating word counters.
// Latency 2 cycles from input acceptance to out_valid, 1 word/cycle throughput.
// Backpressure: out_ready low holds stage 2; a bubble in stage 1 is still filled.
module ecc_enc_pipe
  import ecc_enc_pkg::*;
#(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ecc_enc_pipe_if.slave        io,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [CNT_WIDTH-1:0] illegal_cnt
);

  localparam int CW = MAX_CODEWORD_WIDTH;
  localparam int IW = MAX_INFO_WIDTH;

  mode_e                in_mode;
  logic [IW-1:0]        in_info;
  logic [HAM_MAX_W-1:0] in_ham;

  logic                 v1_q, v1_d;
  logic [IW-1:0]        info1_q, info1_d;
  mode_e                mode1_q, mode1_d;
  logic [HAM_MAX_W-1:0] ham1_q, ham1_d;

  logic                 v2_q, v2_d;
  logic [CW-1:0]        dout_q, dout_d;
  logic                 err_q, err_d;

  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0] ill_cnt_q, ill_cnt_d;

  logic                 ld1, ld2;
  logic [2:0]           p1;
  logic                 overall1;
  logic [CW-1:0]        cw1;

  assign in_mode = mode_e'(io.mod);

  // Stage 2 can take a word when empty or draining; stage 1 likewise behind it.
  assign ld2         = !v2_q || io.out_ready;
  assign ld1         = !v1_q || ld2;
  assign io.in_ready = rst && ld1;

  // Drop info bits above the mode's k so they never reach parity or output.
  always_comb begin
    in_info = '0;
    for (int i = 0; i < IW; i++) begin
      in_info[i] = io.data_in[i] & (i < INFO_W[in_mode]);
    end
  end

  ecc_parity_gen #(
    .INFO_WIDTH (IW)
  ) u_parity_gen (
    .info (in_info),
    .mode (in_mode),
    .ham  (in_ham)
  );

  // Overall even-parity bit and codeword packing for the word held in stage 1.
  always_comb begin
    p1       = 3'(PARITY_W[mode1_q]);
    overall1 = (^info1_q) ^ (^ham1_q);
    cw1      = '0;
    if (mode1_q != MODE_ILLEGAL) begin
      cw1 = (CW'(info1_q) << p1)
          | (CW'(overall1) << (p1 - 3'd1))
          | CW'(ham1_q);
    end
  end

  // Next state of both stages and the saturating counters.
  always_comb begin
    v1_d       = v1_q;
    info1_d    = info1_q;
    mode1_d    = mode1_q;
    ham1_d     = ham1_q;
    v2_d       = v2_q;
    dout_d     = dout_q;
    err_d      = err_q;
    word_cnt_d = word_cnt_q;
    ill_cnt_d  = ill_cnt_q;

    if (ld1) begin
      v1_d = io.in_valid;
      if (io.in_valid) begin
        info1_d = in_info;
        mode1_d = in_mode;
        ham1_d  = in_ham;
      end
    end

    if (ld2) begin
      v2_d = v1_q;
      if (v1_q) begin
        dout_d = cw1;
        err_d  = (mode1_q == MODE_ILLEGAL);
      end
    end

    if (v2_q && io.out_ready) begin
      if (err_q) begin
        if (ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + CNT_WIDTH'(1);
      end else begin
        if (word_cnt_q != '1) word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State registers with synchronous active-low reset; in-flight words are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q       <= 1'b0;
      info1_q    <= '0;
      mode1_q    <= MODE_8_4;
      ham1_q     <= '0;
      v2_q       <= 1'b0;
      dout_q     <= '0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
      ill_cnt_q  <= '0;
    end else begin
      v1_q       <= v1_d;
      info1_q    <= info1_d;
      mode1_q    <= mode1_d;
      ham1_q     <= ham1_d;
      v2_q       <= v2_d;
      dout_q     <= dout_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  assign io.data_out  = dout_q;
  assign io.out_err   = err_q;
  assign io.out_valid = v2_q;
  assign word_cnt     = word_cnt_q;
  assign illegal_cnt  = ill_cnt_q;

endmodule

// File: tb/tb_ecc_enc_pipe.sv
// Bench for ecc_enc_pipe: directed vectors, backpressure and reset corners,
// random traffic against a reference encoder, and counter saturation.
module tb_ecc_enc_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] word_cnt;
  logic [15:0] illegal_cnt;

  always #5 clk = ~clk;

  ecc_enc_pipe_if #(.INFO_WIDTH(26), .CW_WIDTH(32)) bus ();

  ecc_enc_pipe #(
    .MAX_CODEWORD_WIDTH (32),
    .MAX_INFO_WIDTH     (26),
    .CNT_WIDTH          (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .io          (bus.slave),
    .word_cnt    (word_cnt),
    .illegal_cnt (illegal_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [32:0] sb_q[$];
  int          exp_w = 0;
  int          exp_i = 0;
  bit          held_vld = 0;
  logic [31:0] held_dat;
  logic        held_err;

  typedef struct {
    logic [1:0]  m;
    logic [25:0] d;
    logic [31:0] q;
    logic        e;
    int          w;
    int          il;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference encoder: builds the code table by counting non-powers of two,
  // then packs info, overall parity and Hamming bits arithmetically.
  function automatic logic [32:0] ref_enc(input logic [25:0] d, input logic [1:0] m);
    int     k, p, n, par;
    int     codes[26];
    longint info, cw, ones, pbit;
    case (m)
      2'd0:    begin k = 4;  p = 4; end
      2'd1:    begin k = 11; p = 5; end
      2'd2:    begin k = 26; p = 6; end
      default: return {1'b1, 32'h0};
    endcase
    n = 0;
    for (int v = 1; n < k; v++) begin
      if ($countones(v) != 1) begin
        codes[n] = v;
        n++;
      end
    end
    info = longint'(d) & ((longint'(1) << k) - 1);
    par  = 0;
    for (int j = 0; j < p - 1; j++) begin
      int b;
      b = 0;
      for (int i = 0; i < k; i++) begin
        if (d[i] && (((codes[i] >> j) & 1) == 1)) b = b ^ 1;
      end
      par = par | (b << j);
    end
    ones = longint'($countones(info)) + longint'($countones(par));
    pbit = ones % 2;
    cw   = info * (longint'(1) << p) + pbit * (longint'(1) << (p - 1)) + longint'(par);
    return {1'b0, cw[31:0]};
  endfunction

  // One clock: inputs are already set at the negedge; sample, score, advance.
  task automatic tick(output bit acc, output bit rdy);
    bit          rs;
    logic [32:0] e;
    #1;
    rs  = rst;
    rdy = bus.in_ready;
    acc = 0;
    if (rs) begin
      chk("word_cnt", longint'(word_cnt), longint'(exp_w));
      chk("illegal_cnt", longint'(illegal_cnt), longint'(exp_i));
      if (held_vld) begin
        chk("hold_valid", longint'(bus.out_valid), 1);
        chk("hold_data", longint'(bus.data_out), longint'(held_dat));
        chk("hold_err", longint'(bus.out_err), longint'(held_err));
      end
      held_vld = bus.out_valid && !bus.out_ready;
      held_dat = bus.data_out;
      held_err = bus.out_err;
      if (bus.out_valid && bus.out_ready) begin
        chk("out_has_expected_word", longint'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("sb_data", longint'(bus.data_out), longint'(e[31:0]));
          chk("sb_err", longint'(bus.out_err), longint'(e[32]));
          if (e[32]) begin
            if (exp_i < 65535) exp_i++;
          end else begin
            if (exp_w < 65535) exp_w++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(ref_enc(bus.data_in, bus.mod));
        acc = 1;
      end
    end else begin
      chk("in_ready_in_reset", longint'(bus.in_ready), 0);
    end
    @(posedge clk);
    if (!rs) begin
      sb_q.delete();
      exp_w    = 0;
      exp_i    = 0;
      held_vld = 0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    bit a, r;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && sb_q.size() > 0; c++) tick(a, r);
    chk("drained", longint'(sb_q.size()), 0);
  endtask

  initial begin
    bit acc, rdy, seen;
    int w;

    vt[0] = '{m: 2'd0, d: 26'h000000B, q: 32'h0000_00B1, e: 1'b0, w: 1, il: 0};
    vt[1] = '{m: 2'd1, d: 26'h0000001, q: 32'h0000_0033, e: 1'b0, w: 2, il: 0};
    vt[2] = '{m: 2'd1, d: 26'h0000000, q: 32'h0000_0000, e: 1'b0, w: 3, il: 0};
    vt[3] = '{m: 2'd2, d: 26'h3FFFFFF, q: 32'hFFFF_FFFF, e: 1'b0, w: 4, il: 0};
    vt[4] = '{m: 2'd3, d: 26'h2ABCDEF, q: 32'h0000_0000, e: 1'b1, w: 4, il: 1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.data_in   = '0;
    bus.mod       = 2'd0;
    rst           = 1'b0;

    // Reset state.
    @(negedge clk);
    tick(acc, rdy);
    tick(acc, rdy);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_data_out", longint'(bus.data_out), 0);
    chk("rst_out_err", longint'(bus.out_err), 0);
    chk("rst_word_cnt", longint'(word_cnt), 0);
    chk("rst_illegal_cnt", longint'(illegal_cnt), 0);
    chk("post_rst_in_ready", longint'(bus.in_ready), 1);

    // Directed vectors, one word at a time, two-cycle latency.
    for (int v = 0; v < 5; v++) begin
      bus.mod      = vt[v].m;
      bus.data_in  = vt[v].d;
      bus.in_valid = 1'b1;
      tick(acc, rdy);
      chk("vec_accepted", longint'(acc), 1);
      bus.in_valid = 1'b0;
      tick(acc, rdy);
      #1;
      chk("vec_out_valid", longint'(bus.out_valid), 1);
      chk("vec_data_out", longint'(bus.data_out), longint'(vt[v].q));
      chk("vec_out_err", longint'(bus.out_err), longint'(vt[v].e));
      tick(acc, rdy);
      #1;
      chk("vec_word_cnt", longint'(word_cnt), longint'(vt[v].w));
      chk("vec_illegal_cnt", longint'(illegal_cnt), longint'(vt[v].il));
      chk("vec_out_idle", longint'(bus.out_valid), 0);
      @(negedge clk);
    end

    // Backpressure: 5 alternating mode-0/mode-2 words, output stalled 3 cycles.
    w            = 0;
    seen         = 0;
    bus.mod      = 2'd0;
    bus.data_in  = 26'($urandom);
    for (int c = 0; c < 40 && w < 5; c++) begin
      bus.out_ready = (c >= 5);
      bus.in_valid  = 1'b1;
      tick(acc, rdy);
      if (!rdy && !seen) begin
        seen = 1;
        chk("bp_accepted_before_drop", longint'(w), 2);
      end
      if (acc) begin
        w++;
        bus.mod     = (w % 2 == 1) ? 2'd2 : 2'd0;
        bus.data_in = 26'($urandom);
      end
    end
    chk("bp_in_ready_dropped", longint'(seen), 1);
    chk("bp_all_accepted", longint'(w), 5);
    drain();

    // Reset with two words in flight.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.mod       = 2'd2;
    bus.data_in   = 26'h1234567;
    tick(acc, rdy);
    bus.data_in   = 26'h0ABCDEF;
    tick(acc, rdy);
    bus.in_valid  = 1'b0;
    rst           = 1'b0;
    tick(acc, rdy);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    chk("midrst_word_cnt", longint'(word_cnt), 0);
    chk("midrst_illegal_cnt", longint'(illegal_cnt), 0);
    @(negedge clk);
    tick(acc, rdy);
    #1;
    chk("midrst_no_ghost", longint'(bus.out_valid), 0);
    @(negedge clk);

    // Random traffic with random stalls and per-word mode changes.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.mod       = 2'($urandom_range(0, 3));
      bus.data_in   = 26'($urandom);
      tick(acc, rdy);
    end
    drain();

    // Saturation of word_cnt at all-ones.
    rst = 1'b0;
    tick(acc, rdy);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 65540; c++) begin
      bus.mod     = 2'($urandom_range(0, 2));
      bus.data_in = 26'($urandom);
      tick(acc, rdy);
    end
    drain();
    #1;
    chk("sat_word_cnt", longint'(word_cnt), 64'hFFFF);
    chk("sat_illegal_cnt", longint'(illegal_cnt), 0);
    @(negedge clk);
    bus.mod      = 2'd3;
    bus.in_valid = 1'b1;
    tick(acc, rdy);
    drain();
    #1;
    chk("sat_hold_word_cnt", longint'(word_cnt), 64'hFFFF);
    chk("sat_then_illegal", longint'(illegal_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
